flush_arbiter: RTL and testbench
================================

Name: flush_arbiter

Overview:
- Sequences and shares the MPEG bitstream flush-buffer engine between NREQ decoder stages (header parser, VLC decoder, motion-vector decoder, etc.).
- Holds a cached copy of the engine's 32-bit look-ahead window, so each getbits request receives its bits at grant time.
- Serializes flush commands to the engine using a start/done handshake.
- Primes the engine after reset and round-robins the requesters.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NW, 6, width of each requester's bit-count field.
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request; held high until granted.
- req_get  in  NREQ  1 = return bits and flush; 0 = flush only.
- req_n  in  NREQ*NW  packed bit counts; requester i uses bits [i*NW +: NW].
- gnt  out  NREQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  1  one-cycle pulse, coincident with gnt when req_get of the granted requester = 1.
- rsp_data  out  32  granted bits, right-justified and zero-extended.
- fb_start  out  1  one-cycle start pulse to the engine (drives its in_valid).
- fb_n  out  32  flush count to the engine; stable from fb_start until fb_done.
- fb_done  in  1  engine completion pulse.
- fb_word  in  32  engine window (out_ld_bfr); sampled when fb_done = 1.
- win_valid  out  1  cached window holds valid data.
- err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values: gnt = 0, rsp_valid = 0, rsp_data = 0, fb_start = 0, fb_n = 0, win_valid = 0, err = 0, window = 0, rr pointer = 0.
- After reset the FSM is in PRIME.
- A rst asserted in any state, including mid-WAIT, aborts the operation. Any fb_done for the aborted flush is ignored, because the FSM re-enters PRIME.
- States: PRIME, PWAIT, IDLE, ISSUE, WAIT.
- PRIME:
  - Drive fb_start = 1 and fb_n = 0 for one cycle.
  - Go to PWAIT.
- PWAIT:
  - On fb_done: window <= fb_word, win_valid <= 1, go to IDLE.
- IDLE:
  - Pick the first requester with req = 1, searching from the rr pointer upward with wrap-around. The search is combinational.
  - If none, stay in IDLE.
  - Let n = req_n of the winner. If n > 32, saturate n to 32 and set err = 1.
  - Grant cycle: gnt[winner] = 1 and rr pointer <= winner + 1 (mod NREQ).
  - If req_get = 1: rsp_valid = 1 and rsp_data = window >> (32 - n). When n = 0, rsp_data = 0.
  - If n = 0 (peek or no-op): no engine call; stay in IDLE, so back-to-back grants are possible on consecutive cycles.
  - If n > 0: latch fb_n = n, clear win_valid, go to ISSUE.
- ISSUE:
  - fb_start = 1 for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - Hold fb_n and ignore req.
  - On fb_done: window <= fb_word, win_valid <= 1, go to IDLE.
  - New grants are possible starting the cycle after fb_done.
- fb_done is ignored in IDLE and ISSUE.
- Requester rule: a req still high in the cycle after its gnt is a new request.
- Latency:
  - Grant and response occur in the same cycle as selection.
  - The engine starts 1 cycle after the grant.
  - Next grant comes at the earliest 1 cycle after fb_done.
- Simultaneous requests are resolved by rotating priority only; req_get does not affect priority.

Optional Feature:
- Macro: FLUSH_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in PWAIT and WAIT.
  - If it reaches TIMEOUT without fb_done: set err = 1, clear win_valid, go to PRIME to re-prime the engine.
  - The counter clears on every state entry.
- When undefined: no counter; PWAIT and WAIT wait indefinitely.

Test Plan:
- Prime: release rst; the engine returns fb_word = 32'h41000000 after 3 cycles -> exactly one fb_start with fb_n = 0, then win_valid = 1 and the FSM is in IDLE.
- Getbits: window 32'hA5000000; req0 with req_get = 1, n = 8 -> gnt = 4'b0001, rsp_valid = 1, rsp_data = 32'h000000A5, fb_start one cycle later with fb_n = 8.
- Round-robin: req = 4'b1111 held, all n = 4 -> grant order 0, 1, 2, 3, 0, each grant waiting for fb_done.
- Peek: req2 with req_get = 1, n = 0 -> gnt[2] = 1, rsp_data = 0, no fb_start; req3 is granted on the next cycle.
- Saturation: req1 with n = 40, window 32'hDEADBEEF -> rsp_data = 32'hDEADBEEF, fb_n = 32, err = 1 sticky.
- Reset mid-WAIT: assert rst while in WAIT, then deliver fb_done -> outputs at reset values, fb_done ignored, PRIME re-issues fb_start with fb_n = 0.
- With FLUSH_ARB_TIMEOUT_EN and TIMEOUT = 16: withhold fb_done -> err = 1 at cycle 16 of WAIT, then PRIME issues fb_start with fb_n = 0.

Source files
------------

// File: rtl/flush_arbiter_if.sv
// Requester and flush-engine signal bundle for flush_arbiter.
// The master modport is the arbiter side; slave is the requesters plus the engine.
interface flush_arbiter_if #(
    parameter int NREQ = 4,
    parameter int NW   = 6
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_get;
    logic [NREQ*NW-1:0] req_n;
    logic [NREQ-1:0]    gnt;
    logic               rsp_valid;
    logic [31:0]        rsp_data;
    logic               fb_start;
    logic [31:0]        fb_n;
    logic               fb_done;
    logic [31:0]        fb_word;

    modport master (
        input  req, req_get, req_n, fb_done, fb_word,
        output gnt, rsp_valid, rsp_data, fb_start, fb_n
    );

    modport slave (
        output req, req_get, req_n, fb_done, fb_word,
        input  gnt, rsp_valid, rsp_data, fb_start, fb_n
    );
endinterface

// File: rtl/flush_arbiter.sv
// Round-robin sharing of the MPEG flush-buffer engine with a cached 32-bit look-ahead window.
// Define FLUSH_ARB_TIMEOUT_EN to add a watchdog that re-primes the engine after TIMEOUT idle wait cycles.
//
// state | meaning
// PRIME | pulse fb_start with fb_n = 0 to load the first window
// PWAIT | wait for the priming fb_done
// IDLE  | window valid, grant the next requester
// ISSUE | pulse fb_start for the latched flush count
// WAIT  | wait for fb_done, requests ignored
module flush_arbiter #(
    parameter int NREQ    = 4,
    parameter int NW      = 6,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    flush_arbiter_if.master bus,
    output logic            win_valid,
    output logic            err
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {PRIME, PWAIT, IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_next;
    logic [31:0]   window;
    logic [31:0]   fb_n_q;
    logic [PW-1:0] rr_ptr;

    logic          found;
    logic [PW-1:0] winner;
    logic [PW-1:0] idx;
    logic [NW-1:0] n_raw;
    logic [5:0]    n_eff;
    logic          n_over;
    logic          take;
    logic          win_load;
    logic          abort;
    logic          timeout;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        n_raw  = NW'(bus.req_n >> (int'(winner) * NW));
        n_over = 32'(n_raw) > 32'd32;
        n_eff  = n_over ? 6'd32 : 6'(n_raw);
    end

`ifdef FLUSH_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmr;

    // Reloaded outside the wait states, so every entry to PWAIT/WAIT starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || !(state == PWAIT || state == WAIT))
            tmr <= TW'(TIMEOUT - 1);
        else if (tmr != '0)
            tmr <= tmr - 1'b1;
    end

    assign timeout = (state == PWAIT || state == WAIT) && (tmr == '0);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        bus.gnt       = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.fb_start  = 1'b0;
        take          = 1'b0;
        win_load      = 1'b0;
        abort         = 1'b0;
        unique case (state)
            PRIME: begin
                bus.fb_start = 1'b1;
                state_next   = PWAIT;
            end
            PWAIT, WAIT: begin
                if (bus.fb_done) begin
                    win_load   = 1'b1;
                    state_next = IDLE;
                end else if (timeout) begin
                    abort      = 1'b1;
                    state_next = PRIME;
                end
            end
            IDLE: begin
                if (found) begin
                    take            = 1'b1;
                    bus.gnt[winner] = 1'b1;
                    if (bus.req_get[winner]) begin
                        bus.rsp_valid = 1'b1;
                        if (n_eff != '0)
                            bus.rsp_data = window >> (6'd32 - n_eff);
                    end
                    if (n_eff != '0)
                        state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.fb_start = 1'b1;
                state_next   = WAIT;
            end
            default: state_next = PRIME;
        endcase
        // Keep the combinational outputs at their reset values while rst is held.
        if (rst) begin
            bus.gnt       = '0;
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = '0;
            bus.fb_start  = 1'b0;
            take          = 1'b0;
            win_load      = 1'b0;
            abort         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PRIME;
            window    <= '0;
            win_valid <= 1'b0;
            err       <= 1'b0;
            rr_ptr    <= '0;
            fb_n_q    <= '0;
        end else begin
            state <= state_next;
            if (win_load) begin
                window    <= bus.fb_word;
                win_valid <= 1'b1;
            end
            if (take) begin
                rr_ptr <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                if (n_over)
                    err <= 1'b1;
                if (n_eff != '0) begin
                    fb_n_q    <= 32'(n_eff);
                    win_valid <= 1'b0;
                end
            end
            if (abort) begin
                err       <= 1'b1;
                win_valid <= 1'b0;
                fb_n_q    <= '0;
            end
        end
    end

    assign bus.fb_n = fb_n_q;
endmodule

// File: tb/tb_flush_arbiter.sv
// Testbench for flush_arbiter: the bench plays the requesters and the flush engine.
module tb_flush_arbiter;
    localparam int NREQ = 4;
    localparam int NW   = 6;
`ifdef FLUSH_ARB_TIMEOUT_EN
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic win_valid;
    logic err;

    always #5 clk = ~clk;

    flush_arbiter_if #(.NREQ(NREQ), .NW(NW)) bus ();

    flush_arbiter #(.NREQ(NREQ), .NW(NW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .win_valid (win_valid),
        .err       (err)
    );

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // requester side: pending requests
    bit p_req [NREQ];
    bit p_get [NREQ];
    int p_n   [NREQ];
    bit hold_req   = 1'b0;

    // reference model of what the arbiter should show
    logic [31:0] m_window = '0;
    logic [31:0] m_fbn    = '0;
    bit          m_wv     = 1'b0;
    bit          m_err    = 1'b0;
    int          m_rr     = 0;
    bit          m_start_due = 1'b0;
    bit          m_busy   = 1'b0;
    int          m_busy_cyc = 0;
    bit          prev_rst = 1'b1;

    // engine side
    int          eng_cnt   = 0;
    int          eng_delay = 2;
    logic [31:0] eng_word  = '0;
    bit          stray_done = 1'b0;

    // observations
    int          glog[$];
    int          glog_cyc[$];
    int          start_cyc = 0;
    int          n_start   = 0;
    logic [31:0] last_rsp  = '0;
    logic [31:0] last_fbn  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NREQ; i++)
            if (p_req[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle(input bit do_rst);
        bit          gv;
        int          gw;
        int          n;
        int          idx;
        bit          done;
        logic [31:0] exp_rsp;
        rst = do_rst;
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]             = p_req[i];
            bus.req_get[i]         = p_get[i];
            bus.req_n[i*NW +: NW]  = NW'(p_n[i]);
        end
        done        = stray_done || (!do_rst && m_busy && eng_cnt == 0);
        bus.fb_done = done;
        bus.fb_word = eng_word;

        gv = 1'b0;
        gw = 0;
        if (!do_rst && !m_start_due && !m_busy)
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (!gv && p_req[idx]) begin
                    gv = 1'b1;
                    gw = idx;
                end
            end
        n       = gv ? ((p_n[gw] > 32) ? 32 : p_n[gw]) : 0;
        exp_rsp = (gv && p_get[gw] && n > 0) ? (m_window >> (32 - n)) : 32'h0;

        @(negedge clk);
        for (int i = 0; i < NREQ; i++)
            if (bus.gnt[i] === 1'b1) begin
                glog.push_back(i);
                glog_cyc.push_back(cyc);
                last_rsp = bus.rsp_data;
            end
        if (bus.fb_start === 1'b1) begin
            n_start++;
            last_fbn  = bus.fb_n;
            start_cyc = cyc;
        end
        if (do_rst) begin
            chk("rst_gnt", 32'(bus.gnt), 32'h0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            chk("rst_rsp_data", bus.rsp_data, 32'h0);
            chk("rst_fb_start", 32'(bus.fb_start), 32'h0);
            if (prev_rst) begin
                chk("rst_fb_n", bus.fb_n, 32'h0);
                chk("rst_win_valid", 32'(win_valid), 32'h0);
                chk("rst_err", 32'(err), 32'h0);
            end
        end else begin
            chk("gnt", 32'(bus.gnt), gv ? (32'd1 << gw) : 32'd0);
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(gv && p_get[gw]));
            chk("rsp_data", bus.rsp_data, exp_rsp);
            chk("fb_start", 32'(bus.fb_start), 32'(m_start_due));
            if (m_start_due || m_busy)
                chk("fb_n", bus.fb_n, m_fbn);
            chk("win_valid", 32'(win_valid), 32'(m_wv));
            chk("err", 32'(err), 32'(m_err));
        end

        @(posedge clk);
        #1;
        cyc++;
        prev_rst = do_rst;
        if (do_rst) begin
            m_window    = '0;
            m_fbn       = '0;
            m_wv        = 1'b0;
            m_err       = 1'b0;
            m_rr        = 0;
            m_start_due = 1'b1;
            m_busy      = 1'b0;
            for (int i = 0; i < NREQ; i++) p_req[i] = 1'b0;
        end else if (m_start_due) begin
            m_start_due = 1'b0;
            m_busy      = 1'b1;
            m_busy_cyc  = 0;
            eng_cnt     = eng_delay;
        end else if (m_busy) begin
            m_busy_cyc++;
            if (done) begin
                m_window = eng_word;
                m_wv     = 1'b1;
                m_busy   = 1'b0;
            end else if (TO_EN && m_busy_cyc == TO) begin
                m_err       = 1'b1;
                m_wv        = 1'b0;
                m_fbn       = '0;
                m_busy      = 1'b0;
                m_start_due = 1'b1;
            end else begin
                eng_cnt--;
            end
        end else if (gv) begin
            m_rr = (gw + 1) % NREQ;
            if (p_n[gw] > 32) m_err = 1'b1;
            if (n > 0) begin
                m_fbn       = 32'(n);
                m_wv        = 1'b0;
                m_start_due = 1'b1;
            end
            if (!hold_req) p_req[gw] = 1'b0;
        end
    endtask

    task automatic settle();
        for (int g = 0; g < 300; g++) begin
            if (!m_start_due && !m_busy && !any_pending()) break;
            cycle(1'b0);
        end
    endtask

    task automatic set_req(input int i, input bit get, input int n);
        p_req[i] = 1'b1;
        p_get[i] = get;
        p_n[i]   = n;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            p_req[i] = 1'b0;
            p_get[i] = 1'b0;
            p_n[i]   = 0;
        end
        bus.req     = '0;
        bus.req_get = '0;
        bus.req_n   = '0;
        bus.fb_done = 1'b0;
        bus.fb_word = '0;
        rst         = 1'b1;

        // reset and prime
        eng_delay = 2;
        eng_word  = 32'h4100_0000;
        repeat (3) cycle(1'b1);
        n_start = 0;
        settle();
        chk("prime_starts", 32'(n_start), 32'd1);
        chk("prime_fb_n", last_fbn, 32'h0);
        chk("prime_win_valid", 32'(win_valid), 32'h1);

        // getbits: load window A5000000, then read 8 bits
        eng_word = 32'hA500_0000;
        set_req(1, 1'b0, 8);
        settle();
        glog.delete();
        glog_cyc.delete();
        eng_word = $urandom;
        set_req(0, 1'b1, 8);
        settle();
        chk("getbits_gnt", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);
        chk("getbits_rsp", last_rsp, 32'h0000_00A5);
        chk("getbits_fb_n", last_fbn, 32'd8);
        chk("getbits_latency", 32'(start_cyc - (glog_cyc.size() > 0 ? glog_cyc[0] : 0)), 32'd1);

        // round-robin with all requests held, starting from pointer 0
        set_req(3, 1'b0, 4);
        settle();
        glog.delete();
        glog_cyc.delete();
        hold_req = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'(i % 2), 4);
        for (int g = 0; g < 200 && glog.size() < 5; g++) begin
            eng_word = $urandom;
            cycle(1'b0);
        end
        hold_req = 1'b0;
        for (int i = 0; i < NREQ; i++) p_req[i] = 1'b0;
        settle();
        chk("rr_count", 32'(glog.size()), 32'd5);
        for (int k = 0; k < 5 && k < glog.size(); k++)
            chk("rr_order", 32'(glog[k]), 32'(k % NREQ));

        // peek then immediate next grant
        glog.delete();
        glog_cyc.delete();
        eng_word = 32'hDEAD_BEEF;
        set_req(2, 1'b1, 0);
        set_req(3, 1'b0, 4);
        n_start = 0;
        settle();
        chk("peek_first", 32'(glog.size() > 0 ? glog[0] : -1), 32'd2);
        chk("peek_second", 32'(glog.size() > 1 ? glog[1] : -1), 32'd3);
        chk("peek_b2b", 32'(glog_cyc.size() > 1 ? glog_cyc[1] - glog_cyc[0] : 0), 32'd1);
        chk("peek_starts", 32'(n_start), 32'd1);

        // saturation
        eng_word = $urandom;
        set_req(1, 1'b1, 40);
        settle();
        chk("sat_rsp", last_rsp, 32'hDEAD_BEEF);
        chk("sat_fb_n", last_fbn, 32'd32);
        chk("sat_err", 32'(err), 32'h1);

        // reset while waiting on the engine, with a stray fb_done
        eng_delay = 20;
        set_req(0, 1'b0, 5);
        for (int g = 0; g < 50 && !(m_busy && m_busy_cyc >= 2); g++) cycle(1'b0);
        stray_done = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        n_start = 0;
        cycle(1'b0);
        stray_done = 1'b0;
        eng_delay  = 1;
        eng_word   = $urandom;
        settle();
        chk("reprime_starts", 32'(n_start), 32'd1);
        chk("reprime_fb_n", last_fbn, 32'h0);
        chk("reprime_err", 32'(err), 32'h0);

        // engine that does not answer
        n_start = 0;
        set_req(2, 1'b0, 3);
`ifdef FLUSH_ARB_TIMEOUT_EN
        eng_delay = 100000;
        repeat (20) cycle(1'b0);
        chk("to_starts", 32'(n_start), 32'd2);
        chk("to_fb_n", last_fbn, 32'h0);
        chk("to_err", 32'(err), 32'h1);
        eng_cnt   = 0;
        eng_delay = 1;
        settle();
`else
        eng_delay = 40;
        settle();
        chk("slow_starts", 32'(n_start), 32'd1);
        chk("slow_fb_n", last_fbn, 32'd3);
        chk("slow_err", 32'(err), 32'h0);
`endif

        // random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_req[i] && $urandom_range(3) == 0)
                    set_req(i, 1'($urandom_range(1)),
                            ($urandom_range(7) == 0) ? int'($urandom_range(63)) : int'($urandom_range(32)));
            eng_delay = int'($urandom_range(4));
            eng_word  = $urandom;
            cycle(1'b0);
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t expected below 2000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
